// File: rtl/tx_frame_sched.sv
// Transmit frame scheduler: pops rate-buffer entries, validates and clamps them,
// issues one generator request at a time, enforces the inter-frame gap and keeps statistics.
module tx_frame_sched #(
    parameter int unsigned STR_NUM = 8,
    parameter int unsigned IFG_CYC = 12,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 9600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_test_pulse,
    input  logic        tx_test_level,
    input  logic        rb_empty,
    output logic        rb_rd,
    input  logic [17:0] rb_rd_data,
    output logic        gen_req,
    output logic [3:0]  gen_strm,
    output logic [13:0] gen_len,
    input  logic        gen_ack,
    input  logic        gen_done,
    output logic        busy,
    input  logic [2:0]  stat_sel,
    output logic [31:0] stat_cnt,
    output logic [15:0] drop_cnt,
    output logic [15:0] clamp_cnt
);

    localparam int unsigned LEN_W  = 14;
    localparam int unsigned STRM_W = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned SAT_W  = 16;
    localparam int unsigned GAP_W  = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_REQ   = 3'd3,
        S_SEND  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_rb_rd;
    logic                r_gen_req;
    logic                r_busy;
    logic [STRM_W-1:0]   r_gen_strm;
    logic [LEN_W-1:0]    r_gen_len;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_abort;
    logic [CNT_W-1:0]    r_str_cnt [STR_NUM];
    logic [SAT_W-1:0]    r_drop_cnt;
    logic [SAT_W-1:0]    r_clamp_cnt;
    logic [CNT_W-1:0]    r_stat_cnt;

    logic [STRM_W-1:0]   w_strm;
    logic [LEN_W-1:0]    w_len;
    logic                w_strm_ok;
    logic [LEN_W-1:0]    w_len_clamp;
    logic                w_clamp_hit;
    logic                w_load;
    logic                w_drop;
    logic                w_issue;
    logic                w_gap_load;
    logic                w_abort_set;
    logic                w_abort_clr;
    logic [CNT_W-1:0]    w_stat_mux;

    assign w_strm    = rb_rd_data[17:14];
    assign w_len     = rb_rd_data[13:0];
    assign w_strm_ok = (32'(w_strm) < STR_NUM);

    // Length clamp into [MIN_LEN, MAX_LEN]
    always_comb begin
        w_len_clamp = w_len;
        w_clamp_hit = 1'b0;
        if (w_len < LEN_W'(MIN_LEN)) begin
            w_len_clamp = LEN_W'(MIN_LEN);
            w_clamp_hit = 1'b1;
        end else if (w_len > LEN_W'(MAX_LEN)) begin
            w_len_clamp = LEN_W'(MAX_LEN);
            w_clamp_hit = 1'b1;
        end
    end

    // Next-state and per-cycle event decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        w_issue     = 1'b0;
        w_gap_load  = 1'b0;
        w_abort_set = 1'b0;
        w_abort_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_test_level && !rb_empty && !tx_test_pulse) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = tx_test_pulse ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                if (tx_test_pulse) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_strm_ok) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (tx_test_pulse) begin
                    w_state_nxt = S_IDLE;
                end else if (gen_ack) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // A restart mid-frame still lets the frame and its gap finish
                w_abort_set = tx_test_pulse;
                if (gen_done) begin
                    w_gap_load  = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (tx_test_pulse) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap_cnt == '0) begin
                    if (tx_test_level && !rb_empty && !r_abort) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                w_abort_clr = (w_state_nxt != S_GAP);
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and registered control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rb_rd   <= 1'b0;
            r_gen_req <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rb_rd   <= (w_state_nxt == S_FETCH);
            r_gen_req <= (w_state_nxt == S_REQ);
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    // Request payload, gap timer and abort flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gen_strm <= '0;
            r_gen_len  <= '0;
            r_gap_cnt  <= '0;
            r_abort    <= 1'b0;
        end else begin
            if (w_load) begin
                r_gen_strm <= w_strm;
                r_gen_len  <= w_len_clamp;
            end
            if (w_gap_load) begin
                r_gap_cnt <= GAP_W'(IFG_CYC - 1);
            end else if (r_state == S_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
            if (w_abort_set) begin
                r_abort <= 1'b1;
            end else if (w_abort_clr) begin
                r_abort <= 1'b0;
            end
        end
    end

    // Statistics; a test restart clear takes precedence over any increment
    always_ff @(posedge clk) begin
        if (!rst_n || tx_test_pulse) begin
            for (int unsigned i = 0; i < STR_NUM; i++) begin
                r_str_cnt[i] <= '0;
            end
            r_drop_cnt  <= '0;
            r_clamp_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < STR_NUM; i++) begin
                if (w_issue && 32'(r_gen_strm) == i) begin
                    r_str_cnt[i] <= r_str_cnt[i] + CNT_W'(1);
                end
            end
            if (w_drop && r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + SAT_W'(1);
            end
            if (w_load && w_clamp_hit && r_clamp_cnt != '1) begin
                r_clamp_cnt <= r_clamp_cnt + SAT_W'(1);
            end
        end
    end

    always_comb begin
        w_stat_mux = '0;
        for (int unsigned i = 0; i < STR_NUM; i++) begin
            if (32'(stat_sel) == i) begin
                w_stat_mux = r_str_cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_cnt <= '0;
        end else begin
            r_stat_cnt <= w_stat_mux;
        end
    end

    assign rb_rd     = r_rb_rd;
    assign gen_req   = r_gen_req;
    assign gen_strm  = r_gen_strm;
    assign gen_len   = r_gen_len;
    assign busy      = r_busy;
    assign stat_cnt  = r_stat_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign clamp_cnt = r_clamp_cnt;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched with a rate-buffer model and a simple generator responder.
module tb_tx_frame_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, tx_test_pulse, tx_test_level, rb_empty, rb_rd;
    logic [17:0] rb_rd_data;
    logic        gen_req, gen_ack, gen_done, busy;
    logic [3:0]  gen_strm;
    logic [13:0] gen_len;
    logic [2:0]  stat_sel;
    logic [31:0] stat_cnt;
    logic [15:0] drop_cnt, clamp_cnt;

    int nvec = 0;
    int nerr = 0;

    tx_frame_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_test_pulse(tx_test_pulse),
        .tx_test_level(tx_test_level),
        .rb_empty     (rb_empty),
        .rb_rd        (rb_rd),
        .rb_rd_data   (rb_rd_data),
        .gen_req      (gen_req),
        .gen_strm     (gen_strm),
        .gen_len      (gen_len),
        .gen_ack      (gen_ack),
        .gen_done     (gen_done),
        .busy         (busy),
        .stat_sel     (stat_sel),
        .stat_cnt     (stat_cnt),
        .drop_cnt     (drop_cnt),
        .clamp_cnt    (clamp_cnt)
    );

    // Rate buffer model: data appears the cycle after the pop
    logic [17:0] fifo_mem [0:31];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        force_empty = 1'b0;
    assign rb_empty = force_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rb_rd === 1'b1) begin
            rb_rd_data <= fifo_mem[rd_ptr[4:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Generator responder: optional immediate ack and done, plus an injectable done pulse
    logic ack_en = 1'b0, done_en = 1'b0, stray_done = 1'b0, r_send = 1'b0;
    assign gen_ack  = ack_en & gen_req;
    assign gen_done = (done_en & r_send) | stray_done;

    always @(posedge clk) begin
        if (gen_req && gen_ack)       r_send <= 1'b1;
        else if (gen_done && r_send)  r_send <= 1'b0;
    end

    // Event log sampled on the falling edge
    int          cyc = 0;
    int          n_req = 0, n_rd = 0, n_viol = 0;
    int          req_cyc  [0:63];
    logic [3:0]  req_strm [0:63];
    logic [13:0] req_len  [0:63];
    int          rd_cyc   [0:63];
    logic        prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (gen_req === 1'b1 && prev_req !== 1'b1 && n_req < 64) begin
            req_cyc[n_req]  = cyc;
            req_strm[n_req] = gen_strm;
            req_len[n_req]  = gen_len;
            n_req = n_req + 1;
        end
        prev_req = gen_req;
        if (rb_rd === 1'b1 && n_rd < 64) begin
            rd_cyc[n_rd] = cyc;
            n_rd = n_rd + 1;
            if (rb_empty === 1'b1) n_viol = n_viol + 1;
        end
    end

    task automatic push(input logic [3:0] s, input logic [13:0] l);
        fifo_mem[wr_ptr[4:0]] = {s, l};
        wr_ptr = wr_ptr + 1;
    endtask

    // Idle means busy low on two consecutive samples (a drop passes through IDLE for one cycle)
    task automatic wait_idle(input int max, output bit ok);
        int lows = 0;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            lows = (busy === 1'b0) ? lows + 1 : 0;
            if (lows == 2) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (gen_req === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tx_test_pulse = 1'b0; tx_test_level = 1'b0; stat_sel = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++; if (rb_rd !== 1'b0)      begin nerr++; $display("FAIL reset_rb_rd: got %b expected 0", rb_rd); end
        nvec++; if (gen_req !== 1'b0)    begin nerr++; $display("FAIL reset_gen_req: got %b expected 0", gen_req); end
        nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nvec++; if (gen_strm !== 4'd0)   begin nerr++; $display("FAIL reset_gen_strm: got %0d expected 0", gen_strm); end
        nvec++; if (gen_len !== 14'd0)   begin nerr++; $display("FAIL reset_gen_len: got %0d expected 0", gen_len); end
        nvec++; if (stat_cnt !== 32'd0)  begin nerr++; $display("FAIL reset_stat_cnt: got %0d expected 0", stat_cnt); end
        nvec++; if (drop_cnt !== 16'd0)  begin nerr++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        nvec++; if (clamp_cnt !== 16'd0) begin nerr++; $display("FAIL reset_clamp_cnt: got %0d expected 0", clamp_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [3:0]  es [3] = '{4'd1, 4'd2, 4'd1};
        logic [13:0] el [3] = '{14'd100, 14'd200, 14'd1518};
        int b = n_req;
        bit ok;
        ack_en = 1'b1; done_en = 1'b1;
        push(4'd1, 14'd100); push(4'd2, 14'd200); push(4'd1, 14'd1518);
        tx_test_level = 1'b1;
        wait_idle(200, ok);
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL b2b_timeout: busy still %b expected 0", busy); end
        nvec++; if (n_req - b != 3) begin nerr++; $display("FAIL b2b_req_count: got %0d expected 3", n_req - b); end
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (req_strm[b+i] !== es[i] || req_len[b+i] !== el[i]) begin
                nerr++; $display("FAIL b2b_payload%0d: got %0d/%0d expected %0d/%0d", i, req_strm[b+i], req_len[b+i], es[i], el[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            nvec++;
            if (req_cyc[b+i] - req_cyc[b+i-1] != 16) begin
                nerr++; $display("FAIL b2b_period%0d: got %0d expected 16", i, req_cyc[b+i] - req_cyc[b+i-1]);
            end
        end
        stat_sel = 3'd1; repeat (2) @(negedge clk);
        nvec++; if (stat_cnt !== 32'd2) begin nerr++; $display("FAIL b2b_stat1: got %0d expected 2", stat_cnt); end
        stat_sel = 3'd2; repeat (2) @(negedge clk);
        nvec++; if (stat_cnt !== 32'd1) begin nerr++; $display("FAIL b2b_stat2: got %0d expected 1", stat_cnt); end
    endtask

    task automatic test_clamp;
        logic [3:0]  es [3] = '{4'd0, 4'd3, 4'd5};
        logic [13:0] el [3] = '{14'd64, 14'd9600, 14'd64};
        int b = n_req;
        bit ok;
        push(4'd0, 14'd20); push(4'd3, 14'd12000); push(4'd5, 14'd0);
        wait_idle(200, ok);
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL clamp_timeout: busy still %b expected 0", busy); end
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (req_strm[b+i] !== es[i] || req_len[b+i] !== el[i]) begin
                nerr++; $display("FAIL clamp_payload%0d: got %0d/%0d expected %0d/%0d", i, req_strm[b+i], req_len[b+i], es[i], el[i]);
            end
        end
        nvec++; if (clamp_cnt !== 16'd3) begin nerr++; $display("FAIL clamp_cnt: got %0d expected 3", clamp_cnt); end
        nvec++; if (drop_cnt !== 16'd0)  begin nerr++; $display("FAIL clamp_drop_cnt: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_drop;
        int br = n_rd;
        int bq = n_req;
        bit ok;
        push(4'd9, 14'd100); push(4'd4, 14'd300);
        wait_idle(100, ok);
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL drop_timeout: busy still %b expected 0", busy); end
        nvec++; if (n_rd - br != 2) begin nerr++; $display("FAIL drop_rd_count: got %0d expected 2", n_rd - br); end
        nvec++; if (rd_cyc[br+1] - rd_cyc[br] != 3) begin nerr++; $display("FAIL drop_refetch: got %0d expected 3", rd_cyc[br+1] - rd_cyc[br]); end
        nvec++; if (n_req - bq != 1) begin nerr++; $display("FAIL drop_req_count: got %0d expected 1", n_req - bq); end
        nvec++; if (req_strm[bq] !== 4'd4 || req_len[bq] !== 14'd300) begin
            nerr++; $display("FAIL drop_payload: got %0d/%0d expected 4/300", req_strm[bq], req_len[bq]);
        end
        nvec++; if (drop_cnt !== 16'd1) begin nerr++; $display("FAIL drop_cnt: got %0d expected 1", drop_cnt); end
    endtask

    task automatic test_ack_hold;
        int bq = n_req;
        int bad = 0;
        bit ok;
        ack_en = 1'b0; stat_sel = 3'd6;
        push(4'd6, 14'd500);
        wait_req(20, ok);
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL hold_req_timeout: gen_req %b expected 1", gen_req); end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            stray_done = (k == 4);
            if (gen_req !== 1'b1 || gen_strm !== 4'd6 || gen_len !== 14'd500 || stat_cnt !== 32'd0) bad++;
        end
        nvec++; if (bad != 0) begin nerr++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
        ack_en = 1'b1;
        @(negedge clk);
        nvec++; if (gen_req !== 1'b0) begin nerr++; $display("FAIL hold_req_drop: got %b expected 0", gen_req); end
        wait_idle(100, ok);
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL hold_timeout: busy still %b expected 0", busy); end
        nvec++; if (stat_cnt !== 32'd1) begin nerr++; $display("FAIL hold_stat6: got %0d expected 1", stat_cnt); end
        nvec++; if (n_req - bq != 1) begin nerr++; $display("FAIL hold_req_count: got %0d expected 1", n_req - bq); end
    endtask

    task automatic test_abort;
        int bad = 0;
        int rds = 0;
        bit ok;
        ack_en = 1'b1; done_en = 1'b0;
        push(4'd2, 14'd100); push(4'd2, 14'd100);
        wait_req(20, ok);
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL abort_req_timeout: gen_req %b expected 1", gen_req); end
        @(negedge clk);
        nvec++; if (gen_req !== 1'b0) begin nerr++; $display("FAIL abort_send_req: got %b expected 0", gen_req); end
        tx_test_pulse = 1'b1;
        @(negedge clk);
        tx_test_pulse = 1'b0; stray_done = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            stray_done = 1'b0;
            if (busy !== 1'b1 || rb_rd !== 1'b0) bad++;
        end
        nvec++; if (bad != 0) begin nerr++; $display("FAIL abort_gap: got %0d bad gap cycles expected 0", bad); end
        @(negedge clk);
        nvec++; if (busy !== 1'b0)  begin nerr++; $display("FAIL abort_idle_busy: got %b expected 0", busy); end
        nvec++; if (rb_rd !== 1'b0) begin nerr++; $display("FAIL abort_exit_rd: got %b expected 0", rb_rd); end
        tx_test_level = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rb_rd === 1'b1) rds++;
        end
        nvec++; if (rds != 0) begin nerr++; $display("FAIL abort_no_fetch: got %0d pops expected 0", rds); end
        nvec++; if (drop_cnt !== 16'd0)  begin nerr++; $display("FAIL abort_drop_clr: got %0d expected 0", drop_cnt); end
        nvec++; if (clamp_cnt !== 16'd0) begin nerr++; $display("FAIL abort_clamp_clr: got %0d expected 0", clamp_cnt); end
        stat_sel = 3'd2; repeat (2) @(negedge clk);
        nvec++; if (stat_cnt !== 32'd0) begin nerr++; $display("FAIL abort_stat2_clr: got %0d expected 0", stat_cnt); end
        stat_sel = 3'd1; repeat (2) @(negedge clk);
        nvec++; if (stat_cnt !== 32'd0) begin nerr++; $display("FAIL abort_stat1_clr: got %0d expected 0", stat_cnt); end
        done_en = 1'b1;
    endtask

    task automatic test_level_fall;
        int br = n_rd;
        int bq = n_req;
        bit ok;
        ack_en = 1'b0; done_en = 1'b1;
        push(4'd7, 14'd700);
        tx_test_level = 1'b1;
        wait_req(20, ok);
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL lvl_req_timeout: gen_req %b expected 1", gen_req); end
        tx_test_level = 1'b0;
        repeat (3) @(negedge clk);
        ack_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        force_empty = 1'b1;
        wait_idle(60, ok);
        nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL lvl_timeout: busy still %b expected 0", busy); end
        nvec++; if (n_rd - br != 1) begin nerr++; $display("FAIL lvl_rd_count: got %0d expected 1", n_rd - br); end
        nvec++; if (n_req - bq != 1) begin nerr++; $display("FAIL lvl_req_count: got %0d expected 1", n_req - bq); end
        nvec++; if (req_strm[bq] !== 4'd2 || req_len[bq] !== 14'd100) begin
            nerr++; $display("FAIL lvl_payload: got %0d/%0d expected 2/100", req_strm[bq], req_len[bq]);
        end
        stat_sel = 3'd2; repeat (2) @(negedge clk);
        nvec++; if (stat_cnt !== 32'd1) begin nerr++; $display("FAIL lvl_stat2: got %0d expected 1", stat_cnt); end
        nvec++; if (n_viol != 0) begin nerr++; $display("FAIL rd_while_empty: got %0d expected 0", n_viol); end
        force_empty = 1'b0;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_clamp;
        test_drop;
        test_ack_hold;
        test_abort;
        test_level_fall;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tx_frame_sched.md
# tx_frame_sched

Transmit frame scheduler between the bandwidth rate buffer (FIFO of 18-bit `{stream[3:0], length[13:0]}` entries written by the bandwidth controller) and the frame generator. It pops one entry at a time, validates and clamps it, and hands it to the generator over a req/ack handshake. It then waits for frame completion and enforces the inter-frame gap. It also keeps per-stream issued-frame counters plus drop and clamp counters for CPU statistics.

## Interface
- `STR_NUM`, 8: number of valid streams; the stream field must be < `STR_NUM`.
- `IFG_CYC`, 12: idle cycles inserted after each `gen_done`; minimum 1.
- `MIN_LEN`, 64: minimum frame length in bytes.
- `MAX_LEN`, 9600: maximum frame length in bytes; must be ≤ 16383.
- `clk`  in  1  single clock; every register is in this domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tx_test_pulse`  in  1  one-cycle test start/restart; clears the counters.
- `tx_test_level`  in  1  test running; new fetches are allowed only while it is high.
- `rb_empty`  in  1  rate buffer empty.
- `rb_rd`  out  1  rate buffer pop, one-cycle pulse.
- `rb_rd_data`  in  18  `{strm[17:14], len[13:0]}`; valid the cycle after `rb_rd`.
- `gen_req`  out  1  frame request to the generator.
- `gen_strm`  out  4  stream id; stable while `gen_req` is high.
- `gen_len`  out  14  clamped length; stable while `gen_req` is high.
- `gen_ack`  in  1  generator accepts the request.
- `gen_done`  in  1  generator has sent the last byte of the frame.
- `busy`  out  1  high in every state except IDLE.
- `stat_sel`  in  3  selects the per-stream counter.
- `stat_cnt`  out  32  frames issued for stream `stat_sel`; registered.
- `drop_cnt`  out  16  entries dropped because the stream id is ≥ `STR_NUM`; saturates at 0xFFFF.
- `clamp_cnt`  out  16  entries whose length was clamped; saturates at 0xFFFF.

## Operation
- Reset (`rst_n`=0 at a clock edge):
  - State goes to IDLE.
  - `rb_rd`, `gen_req`, `busy` = 0.
  - `gen_strm`, `gen_len` = 0.
  - `stat_cnt`, `drop_cnt`, `clamp_cnt` and all per-stream counters = 0.
  - `abort` flag = 0.
  - Reset has priority over everything else.
- FSM states and transitions:
  - IDLE → FETCH when `tx_test_level` && !`rb_empty` && !`tx_test_pulse`.
  - FETCH: `rb_rd`=1 for exactly this cycle; → LOAD.
  - LOAD: capture `rb_rd_data`.
    - If strm ≥ `STR_NUM`: `drop_cnt`++ and → IDLE; no gap, no request.
    - Otherwise clamp: len < `MIN_LEN` (including 0) → `MIN_LEN`; len > `MAX_LEN` → `MAX_LEN`. Either clamp does `clamp_cnt`++.
    - Load `gen_strm`/`gen_len` and → REQ.
  - REQ: `gen_req`=1. When `gen_ack`=1 → SEND, the per-stream counter[strm]++, and `gen_req` drops the next cycle.
  - SEND: wait for `gen_done` → GAP with the gap counter loaded with `IFG_CYC`-1. `gen_done` outside SEND is ignored.
  - GAP: decrement the counter each cycle. At 0:
    - → FETCH if `tx_test_level` && !`rb_empty` && !`abort`;
    - else → IDLE. `abort` clears on leaving GAP.
- `tx_test_pulse` (when `rst_n`=1):
  - Clears the per-stream, drop and clamp counters in the same cycle. A clear coinciding with an increment wins.
  - In FETCH/LOAD/REQ/GAP: → IDLE next cycle and `gen_req` drops. An entry already popped is discarded without counting.
  - In SEND: set `abort`; the frame completes and the full GAP is still enforced, then → IDLE.
  - In IDLE: blocks the fetch that cycle.
- `tx_test_level` falling: no new FETCH; an in-flight entry completes normally through GAP.
- Counters:
  - Per-stream counters are 32 bits and wrap 0xFFFFFFFF → 0.
  - `drop_cnt` and `clamp_cnt` saturate.
  - `stat_cnt` <= counter[`stat_sel`] every cycle; 1-cycle latency.

## Timing
- Pop to request: `rb_rd` in cycle t, data sampled at t+1, `gen_req` high from t+2.
- `gen_ack` may arrive in the first REQ cycle; minimum REQ time is 1 cycle.
- Minimum entry period, with ack and done each 1 cycle: FETCH 1 + LOAD 1 + REQ 1 + SEND 1 + GAP `IFG_CYC` = `IFG_CYC`+4 cycles.
- Back-to-back: the next `rb_rd` comes in the cycle after the last GAP cycle; IDLE is not visited.
- `rb_rd` is never asserted while `rb_empty`=1 (checked in IDLE and on GAP exit).
- At most one outstanding request; `gen_strm`/`gen_len` change only in LOAD.

## Test plan
- Reset with `rst_n`=0 for 2 cycles → all outputs 0 and `busy`=0. Then `tx_test_level`=1 with 3 entries `{1,100}`, `{2,200}`, `{1,1518}`, ack and done immediate, `IFG_CYC`=12 → three requests exactly 16 cycles apart. Stream 1 counter = 2, stream 2 counter = 1.
- Entries `{0,20}`, `{3,12000}`, `{5,0}` → `gen_len` = 64, 9600, 64 respectively; `clamp_cnt`=3.
- Entry `{9,100}` with `STR_NUM`=8 → no `gen_req`, `drop_cnt`=1, the next entry is fetched 3 cycles after the previous `rb_rd`.
- `gen_ack` held low for 10 cycles → `gen_req`, `gen_strm`, `gen_len` stay stable; counter increments once, on ack. Stray `gen_done` in REQ → ignored.
- `tx_test_pulse` during SEND → the frame finishes, the 12-cycle gap is observed, then IDLE with no fetch despite `rb_empty`=0, and all counters read 0.
- `rb_empty` rises during GAP and `tx_test_level` falls during REQ → no `rb_rd` issued; the in-flight frame completes and `busy` falls after GAP.
